// File: rtl/bundle_issue_ctrl_pkg.sv
// Shared constants and types for the bundle issue controller.
// Slot/source indices, FSM encoding and tag helpers.
package bundle_issue_ctrl_pkg;

  localparam int TAG_W    = 5;
  localparam int NUM_SLOT = 4;
  localparam int NUM_SRC  = 9;
  localparam int NUM_REG  = 32;

  localparam int SLOT_A0 = 0;
  localparam int SLOT_A1 = 1;
  localparam int SLOT_M  = 2;
  localparam int SLOT_LS = 3;

  localparam int SRC_A0_R0 = 0;
  localparam int SRC_A0_R1 = 1;
  localparam int SRC_A1_R0 = 2;
  localparam int SRC_A1_R1 = 3;
  localparam int SRC_M_R0  = 4;
  localparam int SRC_M_R1  = 5;
  localparam int SRC_LS_R0 = 6;
  localparam int SRC_LS_R1 = 7;
  localparam int SRC_LS_R2 = 8;

  localparam logic [TAG_W-1:0] ZERO_TAG = 5'd0;
  localparam logic [4:0]       OP_JUMP  = 5'b01001;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register pending-result counters and the 9-way
// source hazard lookup for the issue controller.
module issue_scoreboard
  import bundle_issue_ctrl_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 2,
  parameter int CNT_W    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [44:0] src_tags,
  input  logic [8:0]  src_used,
  input  logic        issue,
  input  logic [19:0] rd_tags,
  input  logic [3:0]  rd_wr,
  input  logic        ls_load,
  input  logic        m_multi,
  output logic        hazard
);

  localparam int CNT_MAX = (2 ** CNT_W) - 1;

  if (LOAD_LAT > CNT_MAX || (MUL_LAT - 1) > CNT_MAX) begin : g_bad_cnt_w
    $error("issue_scoreboard: CNT_W too narrow for LOAD_LAT/MUL_LAT");
  end

  localparam logic [CNT_W-1:0] LD_V  = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] MUL_V = CNT_W'(MUL_LAT - 1);

  logic [CNT_W-1:0] cnt     [NUM_REG];
  logic [CNT_W-1:0] set_val [NUM_REG];
  logic [CNT_W-1:0] slot_val[NUM_SLOT];
  logic [NUM_REG-1:0] set_en;

  // Hazard: any read, nonzero source whose result is still pending
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_used[i] &&
          src_tags[i*TAG_W +: TAG_W] != ZERO_TAG &&
          cnt[src_tags[i*TAG_W +: TAG_W]] != '0)
        hazard = 1'b1;
    end
  end

  // Wait count each slot loads into its destination on issue
  always_comb begin
    slot_val[SLOT_A0] = '0;
    slot_val[SLOT_A1] = '0;
    slot_val[SLOT_M]  = m_multi ? MUL_V : '0;
    slot_val[SLOT_LS] = ls_load ? LD_V : '0;
  end

  // Destination set requests; later slots override earlier ones
  always_comb begin
    set_en = '0;
    for (int r = 0; r < NUM_REG; r++)
      set_val[r] = '0;
    if (issue) begin
      for (int s = 0; s < NUM_SLOT; s++) begin
        if (rd_wr[s] && rd_tags[s*TAG_W +: TAG_W] != ZERO_TAG) begin
          set_en[rd_tags[s*TAG_W +: TAG_W]]  = 1'b1;
          set_val[rd_tags[s*TAG_W +: TAG_W]] = slot_val[s];
        end
      end
    end
  end

  // Counters: set wins over saturating decrement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REG; r++)
        cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REG; r++) begin
        if (set_en[r])
          cnt[r] <= set_val[r];
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bundle_issue_ctrl.sv
// Issue/hazard controller for the 4-slot bundle between
// decode and execute: stall, bubble, and jump flush.
module bundle_issue_ctrl
  import bundle_issue_ctrl_pkg::*;
#(
  parameter int LOAD_LAT  = 1,
  parameter int MUL_LAT   = 2,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bnd_valid,
  input  logic [44:0] src_tags,
  input  logic [8:0]  src_used,
  input  logic [19:0] rd_tags,
  input  logic [3:0]  rd_wr,
  input  logic        ls_load,
  input  logic        m_multi,
  input  logic        predRW,
  output logic        issue,
  output logic        stall,
  output logic        bubble,
  output logic        flush,
  output logic        err_waw,
  output logic [1:0]  state_o
);

  localparam int FCW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  state_t         state, state_nxt;
  logic [FCW-1:0] fcnt, fcnt_nxt;
  logic           hazard;
  logic           waw;

  issue_scoreboard #(
    .LOAD_LAT (LOAD_LAT),
    .MUL_LAT  (MUL_LAT),
    .CNT_W    (CNT_W)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .src_tags (src_tags),
    .src_used (src_used),
    .issue    (issue),
    .rd_tags  (rd_tags),
    .rd_wr    (rd_wr),
    .ls_load  (ls_load),
    .m_multi  (m_multi),
    .hazard   (hazard)
  );

  // State and flush-window counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // Next state: taken jump beats hazard; flush window counts down
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    unique case (state)
      ST_RUN, ST_STALL: begin
        if (issue && predRW) begin
          state_nxt = ST_FLUSH;
          fcnt_nxt  = FCW'(FLUSH_CYC - 1);
        end else if (bnd_valid && hazard) begin
          state_nxt = ST_STALL;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (fcnt == '0)
          state_nxt = ST_RUN;
        else
          fcnt_nxt = fcnt - FCW'(1);
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Output decode; everything held low while reset is asserted
  always_comb begin
    issue  = 1'b0;
    stall  = 1'b0;
    bubble = 1'b0;
    flush  = 1'b0;
    if (!rst) begin
      unique case (state)
        ST_RUN, ST_STALL: begin
          issue  = bnd_valid & ~hazard;
          stall  = bnd_valid & hazard;
          bubble = bnd_valid & hazard;
        end
        ST_FLUSH: begin
          bubble = 1'b1;
          flush  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Two writing slots aiming at the same nonzero register
  always_comb begin
    waw = 1'b0;
    for (int a = 0; a < NUM_SLOT - 1; a++) begin
      for (int b = a + 1; b < NUM_SLOT; b++) begin
        if (rd_wr[a] && rd_wr[b] &&
            rd_tags[a*TAG_W +: TAG_W] != ZERO_TAG &&
            rd_tags[a*TAG_W +: TAG_W] == rd_tags[b*TAG_W +: TAG_W])
          waw = 1'b1;
      end
    end
  end

  assign err_waw = issue & waw;
  assign state_o = state;

endmodule
